// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub arbiter: FSM states, op-field bit
// positions and datapath widths.
package addsub_pkg;

    // Full operand width and the width of the shared add/sub datapath
    localparam int DW  = 32;
    localparam int HW  = 16;
    localparam int OPW = 3;

    // Bit positions inside the 3-bit op field {wide, signed, sub}
    localparam int SUB    = 0;
    localparam int SIGNED = 1;
    localparam int WIDE   = 2;

    // Arbiter FSM: accept, low half-word, high half-word, hold response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    // Upper half-word of a narrow result: sign copy for signed ops, zero otherwise
    function automatic logic [HW-1:0] narrow_ext(input logic [HW-1:0] lo, input logic is_signed);
        return is_signed ? {HW{lo[HW-1]}} : {HW{1'b0}};
    endfunction

endpackage

// File: rtl/addsub_core.sv
// 16-bit combinational add/sub slice. Chains through cin_i/cout_o so two
// passes build a 32-bit operation. For subtraction cin_i/cout_o are borrows.
module addsub_core
    import addsub_pkg::*;
(
    input  logic [HW-1:0] a_i,
    input  logic [HW-1:0] b_i,
    input  logic          sub_i,
    input  logic          cin_i,
    output logic [HW-1:0] y_o,
    output logic          cout_o,
    output logic          over_o
);

    logic [HW:0] full;

    // One extra bit catches the carry-out, or the wrap that marks a borrow
    always_comb begin
        full = '0;
        if (sub_i) begin
            full = {1'b0, a_i} - {1'b0, b_i} - {{HW{1'b0}}, cin_i};
        end else begin
            full = {1'b0, a_i} + {1'b0, b_i} + {{HW{1'b0}}, cin_i};
        end
        y_o    = full[HW-1:0];
        cout_o = full[HW];
        if (sub_i) begin
            over_o = (a_i[HW-1] != b_i[HW-1]) && (y_o[HW-1] != a_i[HW-1]);
        end else begin
            over_o = (a_i[HW-1] == b_i[HW-1]) && (y_o[HW-1] != a_i[HW-1]);
        end
    end

endmodule

// File: rtl/addsub_arb.sv
// Two-requester arbiter in front of one shared 16-bit add/sub slice.
// Narrow ops take one datapath pass (LO), wide ops take two (LO then HI).
// Optional feature: define ADDSUB_ARB_RR_EN for round-robin tie-breaking;
// without it requester 0 always wins a tie.
module addsub_arb
    import addsub_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    input  logic [OPW-1:0] req0_op,
    input  logic [OPW-1:0] req1_op,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [DW-1:0]  rsp_y,
    output logic           rsp_carry,
    output logic           rsp_over
);

    state_t state_q, state_d;

    // Captured request
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic           id_q, id_d;

    // Result and the carry/borrow passed from the LO pass to the HI pass
    logic [DW-1:0]  y_q, y_d;
    logic           cy_q, cy_d;
    logic           carry_q, carry_d;
    logic           over_q, over_d;

    // Requester operands as indexable arrays
    logic [1:0][DW-1:0]  req_a_arr;
    logic [1:0][DW-1:0]  req_b_arr;
    logic [1:0][OPW-1:0] req_op_arr;

    assign req_a_arr  = {req1_a, req0_a};
    assign req_b_arr  = {req1_b, req0_b};
    assign req_op_arr = {req1_op, req0_op};

    // Tie-break: when set, requester 1 wins if both are valid
    logic prefer1;

`ifdef ADDSUB_ARB_RR_EN
    // Index of the requester granted most recently; reset value favours requester 0
    logic rr_last_q, rr_last_d;
    assign prefer1 = ~rr_last_q;
`else
    assign prefer1 = 1'b0;
`endif

    // Combinational grant, only while idle and not being reset
    logic [1:0] grant;
    always_comb begin
        grant = 2'b00;
        if ((state_q == IDLE) && !rst) begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prefer1 ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Per-requester handshake
    logic [1:0] hs;
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hs
            assign hs[gi]        = req_valid[gi] & grant[gi];
            assign req_ready[gi] = grant[gi];
        end
    endgenerate

    // Datapath operand selection: low half-words in LO, high half-words in HI
    logic [HW-1:0] core_a, core_b, core_y;
    logic          core_cin, core_cout, core_over;

    always_comb begin
        core_a   = a_q[HW-1:0];
        core_b   = b_q[HW-1:0];
        core_cin = 1'b0;
        if (state_q == HI) begin
            core_a   = a_q[DW-1:HW];
            core_b   = b_q[DW-1:HW];
            core_cin = cy_q;
        end
    end

    addsub_core u_core (
        .a_i    (core_a),
        .b_i    (core_b),
        .sub_i  (op_q[SUB]),
        .cin_i  (core_cin),
        .y_o    (core_y),
        .cout_o (core_cout),
        .over_o (core_over)
    );

    // Next-state logic: capture, compute half-words, hold response
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        y_d     = y_q;
        cy_d    = cy_q;
        carry_d = carry_q;
        over_d  = over_q;
`ifdef ADDSUB_ARB_RR_EN
        rr_last_d = rr_last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|hs) begin
                    a_d     = req_a_arr[hs[1]];
                    b_d     = req_b_arr[hs[1]];
                    op_d    = req_op_arr[hs[1]];
                    id_d    = hs[1];
                    state_d = LO;
`ifdef ADDSUB_ARB_RR_EN
                    rr_last_d = hs[1];
`endif
                end
            end
            LO: begin
                y_d[HW-1:0] = core_y;
                cy_d        = core_cout;
                if (op_q[WIDE]) begin
                    state_d = HI;
                end else begin
                    y_d[DW-1:HW] = narrow_ext(core_y, op_q[SIGNED]);
                    carry_d      = op_q[SIGNED] ? 1'b0 : core_cout;
                    over_d       = op_q[SIGNED] ? core_over : 1'b0;
                    state_d      = RESP;
                end
            end
            HI: begin
                y_d[DW-1:HW] = core_y;
                carry_d      = op_q[SIGNED] ? 1'b0 : core_cout;
                over_d       = op_q[SIGNED] ? core_over : 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            y_q     <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            y_q     <= y_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
            over_q  <= over_d;
        end
    end

`ifdef ADDSUB_ARB_RR_EN
    // Round-robin pointer, moves only on a handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    // Response outputs are zero whenever no response is being presented
    logic in_resp;
    assign in_resp   = (state_q == RESP) && !rst;
    assign rsp_valid = in_resp;
    assign rsp_id    = in_resp ? id_q : 1'b0;
    assign rsp_y     = in_resp ? y_q : '0;
    assign rsp_carry = in_resp ? carry_q : 1'b0;
    assign rsp_over  = in_resp ? over_q : 1'b0;

endmodule

// File: tb/tb_addsub_arb.sv
// Self-checking bench for addsub_arb: directed corner cases, arbitration,
// response back-pressure, mid-operation reset and a randomized run, all
// against an arithmetic reference model. Honours ADDSUB_ARB_RR_EN.
module tb_addsub_arb;

`ifdef ADDSUB_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_y;
    logic        rsp_carry, rsp_over;

    int n_cmp  = 0;
    int n_fail = 0;

    // Operands the next transaction presents
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;

    // Model of the arbitration history: 1 means requester 1 was granted last
    bit model_last = 1'b1;

    always #5 clk = ~clk;

    addsub_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req0_op   (req0_op),
        .req1_op   (req1_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_carry (rsp_carry),
        .rsp_over  (rsp_over)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then range tests for carry/overflow
    task automatic ref_calc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            output logic [31:0] y, output logic c, output logic o);
        longint sa, sb, r, mx, mn;
        longint ua, ub, ur, lim;
        bit wide, sgn, sub;
        wide = op[2];
        sgn  = op[1];
        sub  = op[0];
        if (sgn) begin
            if (wide) begin
                sa = $signed(a);
                sb = $signed(b);
                mx = 64'sd2147483647;
                mn = -64'sd2147483648;
            end else begin
                sa = $signed(a[15:0]);
                sb = $signed(b[15:0]);
                mx = 64'sd32767;
                mn = -64'sd32768;
            end
            r = sub ? (sa - sb) : (sa + sb);
            o = (r > mx) || (r < mn);
            c = 1'b0;
            y = wide ? r[31:0] : {{16{r[15]}}, r[15:0]};
        end else begin
            ua  = wide ? longint'({32'd0, a}) : longint'({48'd0, a[15:0]});
            ub  = wide ? longint'({32'd0, b}) : longint'({48'd0, b[15:0]});
            lim = wide ? 64'sd4294967296 : 64'sd65536;
            ur  = sub ? (ua - ub) : (ua + ub);
            c   = sub ? (ua < ub) : (ur >= lim);
            o   = 1'b0;
            y   = wide ? ur[31:0] : {16'h0000, ur[15:0]};
        end
    endtask

    // One transaction, entered and left on a falling edge with the DUT idle.
    // hold = cycles rsp_ready stays low once the response is visible;
    // keep = leave req_valid asserted while the operation runs.
    task automatic txn(input string name, input logic [1:0] mask, input int hold, input bit keep);
        int          g;
        int          lat;
        int          exp_lat;
        bit          got;
        logic [31:0] ea, eb, ey;
        logic [2:0]  eop;
        logic        ec, eo;
        req0_a = a0; req0_b = b0; req0_op = op0;
        req1_a = a1; req1_b = b1; req1_op = op1;
        req_valid = mask;
        #1;
        if (mask == 2'b10)      g = 1;
        else if (mask == 2'b01) g = 0;
        else                    g = (RR_EN && !model_last) ? 1 : 0;
        check({name, " grant"}, {30'd0, req_ready}, (g == 1) ? 32'd2 : 32'd1);
        ea  = (g == 1) ? a1 : a0;
        eb  = (g == 1) ? b1 : b0;
        eop = (g == 1) ? op1 : op0;
        ref_calc(ea, eb, eop, ey, ec, eo);
        exp_lat = eop[2] ? 3 : 2;
        @(posedge clk);
        #1;
        model_last = (g == 1);
        if (!keep) req_valid = 2'b00;
        // Operand changes while busy must not affect the result
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        req0_op = 3'($urandom); req1_op = 3'($urandom);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                lat = i;
            end else begin
                check({name, " busy ready"}, {30'd0, req_ready}, 32'd0);
            end
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " id"}, {31'd0, rsp_id}, g);
        check({name, " y"}, rsp_y, ey);
        check({name, " carry"}, {31'd0, rsp_carry}, {31'd0, ec});
        check({name, " over"}, {31'd0, rsp_over}, {31'd0, eo});
        check({name, " resp ready"}, {30'd0, req_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " stall valid"}, {31'd0, rsp_valid}, 32'd1);
            check({name, " stall y"}, rsp_y, ey);
            check({name, " stall id"}, {31'd0, rsp_id}, g);
            check({name, " stall flags"}, {30'd0, rsp_carry, rsp_over}, {30'd0, ec, eo});
            check({name, " stall ready"}, {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, " done"}, {31'd0, rsp_valid}, 32'd0);
        $display("txn %-10s id=%0d op=%03b a=%08h b=%08h y=%08h c=%0d o=%0d lat=%0d",
                 name, g, eop, ea, eb, ey, ec, eo, lat);
    endtask

    // Synchronous reset for a few cycles with both requesters asking
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("reset ready", {30'd0, req_ready}, 32'd0);
            check("reset valid", {31'd0, rsp_valid}, 32'd0);
        end
        rst = 1'b0;
        req_valid = 2'b00;
        model_last = 1'b1;
        @(negedge clk);
        check("post reset outs", {rsp_y[29:0], rsp_valid, rsp_id}, 32'd0);
        check("post reset flags", {30'd0, rsp_carry, rsp_over}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = '0; req1_op = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
        @(negedge clk);
        do_reset(2);

        // Narrow unsigned add wrapping with carry
        a0 = 32'h0000_FFFF; b0 = 32'h0000_0001; op0 = 3'b000;
        txn("n_uadd", 2'b01, 0, 1'b0);

        // Wide unsigned sub borrowing across the half-word boundary
        a1 = 32'h0001_0000; b1 = 32'h0000_0001; op1 = 3'b101;
        txn("w_usub", 2'b10, 0, 1'b0);

        // Narrow signed add overflow, narrow unsigned sub borrow
        a0 = 32'h0000_7FFF; b0 = 32'h0000_0001; op0 = 3'b010;
        txn("n_sadd", 2'b01, 0, 1'b0);
        a0 = 32'h0000_0001; b0 = 32'h0000_0002; op0 = 3'b001;
        txn("n_usub", 2'b01, 0, 1'b0);

        // Wide signed sub overflow
        a1 = 32'h8000_0000; b1 = 32'h0000_0001; op1 = 3'b111;
        txn("w_ssub", 2'b10, 1, 1'b0);

        // Continuous contention from a fresh reset
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            op0 = 3'($urandom); op1 = 3'($urandom);
            txn("contend", 2'b11, 0, 1'b1);
        end
        req_valid = 2'b00;

        // Long back-pressure with a request waiting
        a0 = 32'h1234_5678; b0 = 32'h0FED_CBA9; op0 = 3'b100;
        a1 = 32'h0000_8000; b1 = 32'h0000_8000; op1 = 3'b010;
        txn("stall", 2'b11, 5, 1'b1);
        req_valid = 2'b00;

        // Reset while the high half-word of a wide op is being computed
        a0 = 32'hFFFF_FFFF; b0 = 32'h0000_0001; op0 = 3'b100;
        req0_a = a0; req0_b = b0; req0_op = op0;
        req_valid = 2'b01;
        #1;
        check("hi_rst grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("hi_rst lo valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("hi_rst hi valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        check("hi_rst outs", {rsp_y[28:0], rsp_valid, rsp_id, rsp_carry}, 32'd0);
        check("hi_rst over/ready", {29'd0, rsp_over, req_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hi_rst no resp", {31'd0, rsp_valid}, 32'd0);
        end
        a0 = 32'h0000_1111; b0 = 32'h0000_2222; op0 = 3'b000;
        a1 = 32'h7FFF_FFFF; b1 = 32'h0000_0001; op1 = 3'b110;
        txn("after_rst", 2'b11, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            op0 = 3'($urandom); op1 = 3'($urandom);
            txn("random", 2'($urandom_range(1, 3)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        req_valid = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/addsub_arb.md
ADDSUB_ARB -- requirements
Module: addsub_arb

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 32 bits and the shared datapath at 16 bits.
REQ-002 SHALL have clock and reset: one clock; reset is synchronous and active-high. The ports are: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-003 SHALL have ports req_valid input 2 (per-requester request valid) and req_ready output 2 (per-requester request accepted).
REQ-004 SHALL have ports req0_a, req0_b, req1_a, req1_b, each input 32 (operands).
REQ-005 SHALL have ports req0_op and req1_op, each input 3. The bits are {wide, signed, sub}: wide=1 means 32-bit, else 16-bit using [15:0]; signed=1 means signed; sub=1 means A-B, else A+B.
REQ-006 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_id output 1 (requester index), rsp_y output 32, rsp_carry output 1 and rsp_over output 1.

Function
REQ-007 SHALL share one 16-bit add/sub datapath between two requesters with a FSM of states IDLE, LO, HI and RESP.
REQ-008 SHALL assert req_ready only in IDLE, only for the granted requester, one-hot or zero. The handshake is req_valid[i]&req_ready[i].
REQ-009 SHALL grant a request combinationally in IDLE. With both valid, arbitration SHALL follow REQ-020/021.
REQ-010 SHALL on acceptance register operands, op and id, then go IDLE->LO.
REQ-011 SHALL in LO compute bits [15:0] with carry-in 0 (add) or borrow-in 0 (sub) and register the result and carry/borrow. A narrow op SHALL then go LO->RESP; a wide op SHALL go LO->HI.
REQ-012 SHALL in HI compute bits [31:16] using the registered carry/borrow from LO, then go HI->RESP.
REQ-013 SHALL hold rsp_valid=1 and all rsp_* stable in RESP until rsp_ready=1, then go to IDLE. No new request SHALL be accepted in that same cycle.
REQ-014 SHALL give latency handshake->rsp_valid of 2 cycles for narrow ops and 3 cycles for wide ops.
REQ-015 SHALL zero-extend rsp_y[31:16] for narrow unsigned ops and sign-extend them for narrow signed ops.
REQ-016 SHALL for unsigned ops drive rsp_carry = carry-out (add) or borrow, meaning A<B (sub), taken from the top bit of the operation width, and drive rsp_over=0.
REQ-017 SHALL for signed ops drive rsp_carry=0 and rsp_over = two's-complement overflow of the top word. Add overflow is: operand signs equal and result sign differs. Sub overflow is: operand signs differ and result sign differs from A.
REQ-018 SHALL ignore req_valid changes while not in IDLE; requests are not queued.

Reset
REQ-019 SHALL on rst=1 at a clock edge enter IDLE from any state, abandoning any in-flight operation without producing a response. It SHALL drive rsp_valid=0, rsp_id=0, rsp_y=0, rsp_carry=0, rsp_over=0 and req_ready=0 for that cycle, and set the round-robin pointer to favour requester 0.

Configuration
REQ-020 SHALL with ADDSUB_ARB_RR_EN defined use round-robin arbitration. On a tie the requester not granted last SHALL win; the pointer updates only on handshake.
REQ-021 SHALL without ADDSUB_ARB_RR_EN use fixed priority, with requester 0 always winning a tie; no pointer register exists.

Structure
REQ-022 SHALL place the FSM state enum, the op-field bit positions (WIDE, SIGNED, SUB) and the width constants (DW=32, HW=16) in shared package addsub_pkg.
REQ-023 SHALL instantiate one sub-module addsub_core. It is a 16-bit combinational add/sub with carry/borrow-in, carry/borrow-out and signed-overflow outputs. The arbiter owns all registers.

Verification
REQ-024 SHALL cover: req0 narrow unsigned add 0xFFFF+0x0001 -> rsp_y=0x00000000, carry=1, over=0, rsp_valid 2 cycles after the handshake.
REQ-025 SHALL cover: req1 wide unsigned sub 0x00010000-0x00000001 -> rsp_y=0x0000FFFF, carry=0, rsp_id=1, rsp_valid 3 cycles after the handshake.
REQ-026 SHALL cover: narrow signed add 0x7FFF+0x0001 -> rsp_y=0xFFFF8000, over=1, carry=0; and narrow unsigned sub 0x0001-0x0002 -> rsp_y=0x0000FFFF, carry=1.
REQ-027 SHALL cover: both requesters valid continuously for 4 operations -> with RR_EN, grants alternate 0,1,0,1; without RR_EN, all grants go to requester 0.
REQ-028 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable and req_ready=0 throughout; acceptance resumes the cycle after IDLE is re-entered.
REQ-029 SHALL cover: rst asserted during HI of a wide op -> no response is ever produced, next cycle is IDLE with all outputs 0, and a fresh request completes correctly.
